// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and types for the FIR coefficient path
package fir_pkg;

   localparam int FIR_TAPS = 25;
   localparam int FIR_CW   = 8;

   typedef logic [FIR_CW-1:0] fir_coef_t;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } fir_ld_state_t;

endpackage

// File: rtl/fir_coef_buf.sv
// rtl/fir_coef_buf.sv - TAPS x CW coefficient store, sync write, comb read
module fir_coef_buf
   import fir_pkg::*;
#(
   parameter int TAPS = FIR_TAPS,
   parameter int CW   = FIR_CW,
   parameter int AW   = $clog2(TAPS)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [CW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [CW-1:0] rdata_o
);

   // Contents deliberately survive reset; only the loader's indices are cleared.
   logic [CW-1:0] mem_q [TAPS];

   // Write port: one word per accepted stream beat.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - collects a coefficient set and replays it reversed into the filter (optional FIR_COEF_SUM_EN running sum)
module fir_coef_loader
   import fir_pkg::*;
#(
   parameter int TAPS = FIR_TAPS,
   parameter int CW   = FIR_CW
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [CW-1:0]                coef_data,
   input  logic                         coef_valid,
   output logic                         coef_ready,
   input  logic                         flush,
   output logic [CW-1:0]                coef_out,
   output logic                         load_c,
   output logic                         busy,
   output logic                         done,
   output logic [CW+$clog2(TAPS)-1:0]   coef_sum
);

   localparam int IW = $clog2(TAPS);
   localparam int SW = CW + IW;
   localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

   fir_ld_state_t state_q, state_d;
   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [IW-1:0] rd_idx_q, rd_idx_d;
   logic [CW-1:0] coef_out_q, coef_out_d;
   logic          load_c_q, load_c_d;
   logic          done_q, done_d;
   logic          buf_we;
   logic [IW-1:0] rd_addr;
   logic [CW-1:0] rd_data;

   // flush wins over a coincident beat, so that beat never reaches the buffer.
   assign buf_we = (state_q == FILL) && coef_valid && !flush;

   fir_coef_buf #(
      .TAPS (TAPS),
      .CW   (CW),
      .AW   (IW)
   ) u_buf (
      .clk     (clk),
      .we_i    (buf_we),
      .waddr_i (wr_idx_q),
      .wdata_i (coef_data),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   // Next-state and registered-output precompute; coef_out is fetched one cycle ahead.
   always_comb begin
      state_d    = state_q;
      wr_idx_d   = wr_idx_q;
      rd_idx_d   = rd_idx_q;
      coef_out_d = '0;
      load_c_d   = 1'b0;
      done_d     = 1'b0;
      rd_addr    = '0;
      case (state_q)
         FILL: begin
            if (flush) begin
               wr_idx_d = '0;
            end else if (coef_valid) begin
               if (wr_idx_q == LAST_IDX) begin
                  wr_idx_d   = '0;
                  rd_idx_d   = '0;
                  state_d    = LOAD;
                  load_c_d   = 1'b1;
                  // h[TAPS-1] is being written this very edge; forward it.
                  coef_out_d = coef_data;
               end else begin
                  wr_idx_d = wr_idx_q + 1'b1;
               end
            end
         end
         LOAD: begin
            if (rd_idx_q == LAST_IDX) begin
               rd_idx_d = '0;
               state_d  = DONE;
               done_d   = 1'b1;
            end else begin
               rd_idx_d   = rd_idx_q + 1'b1;
               load_c_d   = 1'b1;
               rd_addr    = LAST_IDX - IW'(1) - rd_idx_q;
               coef_out_d = rd_data;
            end
         end
         DONE: begin
            state_d = FILL;
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // State, indices and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FILL;
         wr_idx_q   <= '0;
         rd_idx_q   <= '0;
         coef_out_q <= '0;
         load_c_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_idx_q   <= wr_idx_d;
         rd_idx_q   <= rd_idx_d;
         coef_out_q <= coef_out_d;
         load_c_q   <= load_c_d;
         done_q     <= done_d;
      end
   end

   assign coef_ready = (state_q == FILL);
   assign busy       = (state_q != FILL);
   assign coef_out   = coef_out_q;
   assign load_c     = load_c_q;
   assign done       = done_q;

`ifdef FIR_COEF_SUM_EN
   logic [SW-1:0] sum_q, sum_d;

   // Running sum restarts on the first word of a set and holds after the last.
   always_comb begin
      sum_d = sum_q;
      if (state_q == FILL) begin
         if (flush) begin
            sum_d = '0;
         end else if (coef_valid) begin
            sum_d = (wr_idx_q == '0) ? SW'(coef_data) : sum_q + SW'(coef_data);
         end
      end
   end

   // Accumulator register.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign coef_sum = sum_q;
`else
   assign coef_sum = '0;
`endif

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb/tb_fir_coef_loader.sv - self-checking bench for fir_coef_loader
module tb_fir_coef_loader;

   localparam int TAPS = 25;
   localparam int CW   = 8;
   localparam int SW   = 13;

   typedef logic [CW-1:0] set_t [TAPS];

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [CW-1:0] coef_data = '0;
   logic          coef_valid = 1'b0;
   logic          flush = 1'b0;
   logic          coef_ready;
   logic [CW-1:0] coef_out;
   logic          load_c;
   logic          busy;
   logic          done;
   logic [SW-1:0] coef_sum;

   int checks = 0;
   int errors = 0;

   fir_coef_loader #(.TAPS(TAPS), .CW(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .coef_data  (coef_data),
      .coef_valid (coef_valid),
      .coef_ready (coef_ready),
      .flush      (flush),
      .coef_out   (coef_out),
      .load_c     (load_c),
      .busy       (busy),
      .done       (done),
      .coef_sum   (coef_sum)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: sum of the set, or zero when the accumulator is compiled out.
   function automatic logic [31:0] exp_sum(input set_t w);
      int s = 0;
`ifdef FIR_COEF_SUM_EN
      foreach (w[i]) s += int'(w[i]);
`endif
      return s;
   endfunction

   function automatic set_t rand_set();
      set_t w;
      foreach (w[i]) w[i] = CW'($urandom);
      return w;
   endfunction

   // Stream one set; returns in the cycle after the final accept.
   task automatic feed(input set_t w, input bit gaps, input bit hold_valid);
      int  k = 0;
      int  guard = 0;
      bit  tog = 1'b0;
      while (k < TAPS) begin
         coef_valid = gaps ? tog : 1'b1;
         coef_data  = coef_valid ? w[k] : CW'($urandom);
         tog = !tog;
         chk("ready_in_fill", {31'd0, coef_ready}, 32'd1);
         step();
         if (coef_valid) k++;
         guard++;
         if (guard > 4 * TAPS) begin
            chk("feed_timeout", 32'd0, 32'd1);
            break;
         end
      end
      coef_valid = hold_valid;
      coef_data  = CW'($urandom);
   endtask

   // Expect TAPS reversed load beats, one done cycle, then ready again.
   task automatic check_load(input set_t w);
      int low = 0;
      for (int i = 0; i < TAPS; i++) begin
         chk("load_c_high", {31'd0, load_c}, 32'd1);
         chk("coef_out", {24'd0, coef_out}, {24'd0, w[TAPS-1-i]});
         chk("ready_low_load", {31'd0, coef_ready}, 32'd0);
         chk("busy_load", {31'd0, busy}, 32'd1);
         if (i == 0) chk("sum_hold", {19'd0, coef_sum}, exp_sum(w));
         if (!coef_ready) low++;
         coef_data = CW'($urandom);
         step();
      end
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("load_c_after", {31'd0, load_c}, 32'd0);
      chk("busy_done", {31'd0, busy}, 32'd1);
      if (!coef_ready) low++;
      step();
      chk("done_cleared", {31'd0, done}, 32'd0);
      chk("ready_back", {31'd0, coef_ready}, 32'd1);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("ready_low_cycles", low, TAPS + 1);
      chk("sum_final", {19'd0, coef_sum}, exp_sum(w));
   endtask

   initial begin
      set_t ramp, w, flat;
      foreach (ramp[i]) ramp[i] = CW'(i + 1);
      foreach (flat[i]) flat[i] = 8'h80;

      // Reset state.
      step();
      step();
      chk("rst_ready", {31'd0, coef_ready}, 32'd1);
      chk("rst_load_c", {31'd0, load_c}, 32'd0);
      chk("rst_coef_out", {24'd0, coef_out}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sum", {19'd0, coef_sum}, 32'd0);
      reset = 1'b0;

      // Ramp load, valid held high.
      feed(ramp, 1'b0, 1'b0);
      check_load(ramp);
`ifdef FIR_COEF_SUM_EN
      chk("ramp_sum_325", {19'd0, coef_sum}, 32'd325);
`endif

      // Same ramp with valid gaps.
      feed(ramp, 1'b1, 1'b0);
      check_load(ramp);

      // Flush after 10 words, coincident with an 11th beat.
      w = rand_set();
      for (int i = 0; i < 10; i++) begin
         coef_valid = 1'b1;
         coef_data  = w[i];
         step();
      end
      coef_data = 8'h5A;
      flush = 1'b1;
      chk("ready_on_flush", {31'd0, coef_ready}, 32'd1);
      step();
      flush = 1'b0;
      coef_valid = 1'b0;
      chk("no_load_after_flush", {31'd0, load_c}, 32'd0);
      chk("sum_flushed", {19'd0, coef_sum}, 32'd0);
      feed(flat, 1'b0, 1'b0);
      check_load(flat);
`ifdef FIR_COEF_SUM_EN
      chk("flush_sum_3200", {19'd0, coef_sum}, 32'd3200);
`endif

      // Reset on the 5th load cycle.
      w = rand_set();
      feed(w, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("pre_reset_load", {24'd0, coef_out}, {24'd0, w[TAPS-1-i]});
         step();
      end
      chk("fifth_load", {31'd0, load_c}, 32'd1);
      reset = 1'b1;
      step();
      chk("rst_mid_load_c", {31'd0, load_c}, 32'd0);
      chk("rst_mid_ready", {31'd0, coef_ready}, 32'd1);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_sum", {19'd0, coef_sum}, 32'd0);
      reset = 1'b0;
      w = rand_set();
      feed(w, 1'b0, 1'b0);
      check_load(w);

      // Random sets, random gap mode.
      for (int n = 0; n < 4; n++) begin
         w = rand_set();
         feed(w, 1'($urandom_range(0, 1)), 1'b0);
         check_load(w);
      end

      // Back-to-back sets, valid held high throughout.
      w = rand_set();
      feed(w, 1'b0, 1'b1);
      check_load(w);
      w = rand_set();
      feed(w, 1'b0, 1'b1);
      check_load(w);
      coef_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_coef_loader.md
# fir_coef_loader

Upstream companion to the 25-tap FIR filter. It accepts a coefficient set over a valid/ready stream in natural order h[0] first and stores all TAPS words locally. It then replays them in reverse order on a registered coef_out/load_c pair, so that after TAPS load cycles each filter tap k holds h[k]. While it loads, the filter's sample shift and output update are frozen.

## Interface
Parameters:
- TAPS, 25, number of coefficients per set; must match the filter.
- CW, 8, coefficient width in bits.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- coef_data  in  CW  incoming coefficient word
- coef_valid  in  1  coef_data is valid this cycle
- coef_ready  out  1  loader can accept a word this cycle
- flush  in  1  discard any partially received set
- coef_out  out  CW  coefficient to the filter's coef_in
- load_c  out  1  load strobe to the filter's load_c
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle pulse after the final load cycle
- coef_sum  out  CW+5  running sum of the set; see Configuration

## Operation
- FSM states are FILL, LOAD and DONE. Reset enters FILL.
- FILL:
  - coef_ready=1.
  - A word is accepted on coef_valid&coef_ready; it is written to buf[wr_idx] and wr_idx increments.
  - On the accept where wr_idx==TAPS-1, wr_idx clears and the state moves to LOAD.
- LOAD:
  - coef_ready=0.
  - Runs exactly TAPS cycles with load_c=1 and coef_out=buf[TAPS-1-rd_idx], for rd_idx = 0..TAPS-1.
  - After the cycle with rd_idx==TAPS-1, the state moves to DONE.
- DONE: lasts one cycle with done=1, then returns to FILL.
- flush:
  - In FILL it clears wr_idx and takes priority over a simultaneous accept; that word is dropped.
  - In LOAD and DONE it is ignored, so an in-progress load always completes.
- coef_valid is ignored outside FILL; no word is lost because coef_ready=0 there.
- buf contents are not cleared on reset; only the indices and the state are.
- Arithmetic:
  - Indices are $clog2(TAPS) bits wide and are compared against TAPS-1; they never wrap past TAPS-1.
  - coef_sum is unsigned with width CW+$clog2(TAPS), which is 13 for the defaults. It cannot overflow.

## Timing
- Reset values: coef_ready=1, load_c=0, coef_out=0, busy=0, done=0, coef_sum=0.
- coef_out, load_c and done are registered outputs. coef_ready and busy decode directly from the state register.
- If the final word of a set is accepted on cycle N:
  - load_c is high on cycles N+1..N+TAPS.
  - coef_out on cycle N+1 is h[TAPS-1], and on cycle N+TAPS it is h[0].
  - done is high on cycle N+TAPS+1.
  - coef_ready rises again on cycle N+TAPS+2.
- Back-to-back sets are allowed. Minimum set-to-set spacing is 2·TAPS+1 cycles.
- Reset mid-LOAD: load_c is 0 from the next cycle. The filter is reset by the same signal, so no partial set survives.
- load_c never has a gap inside a set. The filter relies on exactly TAPS contiguous shifts.

## Configuration
- FIR_COEF_SUM_EN defined:
  - coef_sum accumulates each accepted word.
  - It clears on reset, on flush, and on the first accept of a new set.
  - It holds the final sum from the last accept of a set until the first accept of the next set.
- FIR_COEF_SUM_EN undefined: coef_sum is tied to 0 and the accumulator logic is removed. The port is still present.

## Structure
- Shared package fir_pkg holds:
  - constants FIR_TAPS=25 and FIR_CW=8;
  - the state enum typedef fir_ld_state_t {FILL, LOAD, DONE};
  - the typedef for coefficient words.
- The coefficient buffer is one sub-module, fir_coef_buf: TAPS×CW, one synchronous write port and one combinational read port.
- The FSM, counters and accumulator stay in the top module.

## Test plan
- Ramp load: feed h[k]=k+1 for k=0..24 with coef_valid held high.
  - load_c is high for exactly 25 cycles.
  - coef_out runs 25,24,…,1.
  - done pulses once.
  - coef_sum=325.
- Valid gaps: the same set with coef_valid toggling every other cycle. Load output is identical to the ramp load; no words are lost or duplicated.
- Flush: accept 10 words, pulse flush together with an 11th valid word, then send a full set of 0x80.
  - All 25 coef_out values are 0x80.
  - coef_sum=3200 (0xC80).
- Reset mid-LOAD: assert reset on the 5th load cycle.
  - load_c=0 and coef_ready=1 on the next cycle.
  - A fresh set then loads normally.
- End to end with the filter: load h[0]=0xFF and the other taps 0, then drive an impulse of 0x80. The filter's data_out shows 0x7F once, at its normal latency.
- Back-to-back sets: two full sets streamed with valid held high. coef_ready is 0 for exactly 26 cycles between them.
